// File: rtl/snn_pkg.sv
// Shared Q16.16 fixed-point constants and FSM state type for the spiking-neuron datapath.
package snn_pkg;

  localparam int Q_WIDTH = 32;
  localparam int Q_FRAC  = 16;

  localparam logic signed [Q_WIDTH-1:0] Q_ONE = 32'sh0001_0000;
  localparam logic signed [Q_WIDTH-1:0] Q_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [Q_WIDTH-1:0] Q_MIN = 32'sh8000_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    UPDATE = 2'd2
  } syn_state_t;

endpackage

// File: rtl/syn_weight_rf.sv
// Per-synapse Q16.16 weight register file: one synchronous write port,
// one combinational read port, all weights cleared by the async reset.
module syn_weight_rf
  import snn_pkg::*;
#(
  parameter int N_INPUTS = 8,
  parameter int ADDR_W   = $clog2(N_INPUTS)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               i_wr_en,
  input  logic [ADDR_W-1:0]  i_wr_addr,
  input  logic [Q_WIDTH-1:0] i_wr_data,
  input  logic [ADDR_W-1:0]  i_rd_addr,
  output logic [Q_WIDTH-1:0] o_rd_data
);

  logic [Q_WIDTH-1:0] r_weights [N_INPUTS];
  logic               w_wr_in_range;

  // Writes to addresses past N_INPUTS-1 (non-power-of-two sizes) are dropped.
  assign w_wr_in_range = (32'(i_wr_addr) < N_INPUTS);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_INPUTS; i++) begin
        r_weights[i] <= '0;
      end
    end else if (i_wr_en && w_wr_in_range) begin
      r_weights[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_weights[i_rd_addr];

endmodule

// File: rtl/synaptic_current_integrator.sv
// Serial synaptic-current integrator with shift-based exponential decay.
// Define SYN_CURRENT_SAT_EN to saturate the updated current instead of wrapping it.
module synaptic_current_integrator
  import snn_pkg::*;
#(
  parameter int N_INPUTS    = 8,
  parameter int DECAY_SHIFT = 3
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        step,
  input  logic [N_INPUTS-1:0]         spike_in,
  input  logic                        wr_en,
  input  logic [$clog2(N_INPUTS)-1:0] wr_addr,
  input  logic [Q_WIDTH-1:0]          wr_data,
  output logic [Q_WIDTH-1:0]          current,
  output logic                        current_valid,
  output logic                        busy,
  output logic                        overrun
);

  localparam int IDX_W  = $clog2(N_INPUTS);
  localparam int SUM_W  = Q_WIDTH + IDX_W + 1;
  localparam int NEXT_W = SUM_W + 1;

  syn_state_t                 r_state;
  logic [N_INPUTS-1:0]        r_spikes;
  logic [IDX_W-1:0]           r_idx;
  logic signed [SUM_W-1:0]    r_sum;
  logic signed [Q_WIDTH-1:0]  r_current;
  logic                       r_current_valid;
  logic                       r_overrun;

  logic [Q_WIDTH-1:0]         w_weight;
  logic                       w_last;
  logic signed [SUM_W-1:0]    w_addend;
  logic signed [NEXT_W-1:0]   w_cur_ext;
  logic signed [NEXT_W-1:0]   w_decay;
  logic signed [NEXT_W-1:0]   w_sum_ext;
  logic signed [NEXT_W-1:0]   w_next;
  logic signed [Q_WIDTH-1:0]  w_next_q;

  syn_weight_rf #(
    .N_INPUTS (N_INPUTS),
    .ADDR_W   (IDX_W)
  ) u_weight_rf (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_wr_en   (wr_en),
    .i_wr_addr (wr_addr),
    .i_wr_data (wr_data),
    .i_rd_addr (r_idx),
    .o_rd_data (w_weight)
  );

  assign w_last   = (r_idx == IDX_W'(N_INPUTS - 1));
  assign w_addend = r_spikes[r_idx] ? {{(SUM_W-Q_WIDTH){w_weight[Q_WIDTH-1]}}, w_weight}
                                    : '0;

  // Decay and accumulation run one bit wider than sum so the result never wraps.
  assign w_cur_ext = {{(NEXT_W-Q_WIDTH){r_current[Q_WIDTH-1]}}, r_current};
  assign w_decay   = w_cur_ext >>> DECAY_SHIFT;
  assign w_sum_ext = {r_sum[SUM_W-1], r_sum};
  assign w_next    = w_cur_ext - w_decay + w_sum_ext;

`ifdef SYN_CURRENT_SAT_EN
  logic w_over;
  logic w_under;

  assign w_over   = !w_next[NEXT_W-1] && (|w_next[NEXT_W-2:Q_WIDTH-1]);
  assign w_under  =  w_next[NEXT_W-1] && !(&w_next[NEXT_W-2:Q_WIDTH-1]);
  assign w_next_q = w_over  ? Q_MAX :
                    w_under ? Q_MIN :
                              w_next[Q_WIDTH-1:0];
`else
  logic w_unused_hi;

  assign w_next_q    = w_next[Q_WIDTH-1:0];
  assign w_unused_hi = ^w_next[NEXT_W-1:Q_WIDTH];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= IDLE;
      r_spikes        <= '0;
      r_idx           <= '0;
      r_sum           <= '0;
      r_current       <= '0;
      r_current_valid <= 1'b0;
      r_overrun       <= 1'b0;
    end else begin
      r_current_valid <= 1'b0;
      r_overrun       <= step && (r_state != IDLE);
      case (r_state)
        IDLE: begin
          if (step) begin
            r_spikes <= spike_in;
            r_sum    <= '0;
            r_idx    <= '0;
            r_state  <= ACCUM;
          end
        end
        ACCUM: begin
          r_sum <= r_sum + w_addend;
          if (w_last) begin
            r_state <= UPDATE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        UPDATE: begin
          r_current       <= w_next_q;
          r_current_valid <= 1'b1;
          r_state         <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign current       = r_current;
  assign current_valid = r_current_valid;
  assign busy          = (r_state != IDLE);
  assign overrun       = r_overrun;

endmodule

// File: tb/tb_synaptic_current_integrator.sv
// Directed testbench for synaptic_current_integrator (N_INPUTS=8, DECAY_SHIFT=3);
// expectations follow SYN_CURRENT_SAT_EN when the saturation case is checked.
module tb_synaptic_current_integrator;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        step = 1'b0;
  logic [7:0]  spike_in = '0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] current;
  logic        current_valid;
  logic        busy;
  logic        overrun;

  int checkCount = 0;
  int errorCount = 0;
  int validCount = 0;
  int overrunCount = 0;
  int latency;
  int validBase;
  int overrunBase;

  synaptic_current_integrator #(
    .N_INPUTS    (8),
    .DECAY_SHIFT (3)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .step          (step),
    .spike_in      (spike_in),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .current       (current),
    .current_valid (current_valid),
    .busy          (busy),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (current_valid) validCount++;
    if (overrun) overrunCount++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    reset_n = 1'b0;
    step = 1'b0;
    wr_en = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic writeWeight(input logic [2:0] addr, input logic [31:0] data);
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = addr;
    wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // One integration pass; optionally re-strobe step or write a weight at cycle n after acceptance.
  task automatic applyStimulus(input logic [7:0] spikes, input int extraStepAt,
                               input int wrAt, input logic [2:0] wAddr,
                               input logic [31:0] wData, output int lat);
    lat = -1;
    @(negedge clk);
    step = 1'b1;
    spike_in = spikes;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      step = (n == extraStepAt);
      spike_in = ~spikes;
      wr_en = (n == wrAt);
      wr_addr = wAddr;
      wr_data = wData;
      if (current_valid) begin
        lat = n - 1;
        break;
      end
    end
    step = 1'b0;
    wr_en = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("valid one cycle", {63'd0, current_valid}, 64'd0);
    checkOutput("busy after pass", {63'd0, busy}, 64'd0);
  endtask

  task automatic runStep(input string tag, input logic [7:0] spikes, input logic [31:0] expected);
    applyStimulus(spikes, 0, 0, 3'd0, 32'd0, latency);
    checkOutput({tag, " latency"}, 64'(latency), 64'd9);
    checkOutput({tag, " current"}, {32'd0, current}, {32'd0, expected});
  endtask

  initial begin
    logic [31:0] satExpected;
`ifdef SYN_CURRENT_SAT_EN
    satExpected = 32'h7FFF_FFFF;
`else
    satExpected = 32'hFFF8_0000;
`endif

    doReset();
    #1;
    checkOutput("reset current", {32'd0, current}, 64'd0);
    checkOutput("reset valid", {63'd0, current_valid}, 64'd0);
    checkOutput("reset busy", {63'd0, busy}, 64'd0);
    checkOutput("reset overrun", {63'd0, overrun}, 64'd0);

    $display("[TB] single spike and decay");
    writeWeight(3'd0, 32'h000A_0000);
    runStep("single", 8'h01, 32'h000A_0000);
    runStep("decay pos", 8'h00, 32'h0008_C000);

    $display("[TB] negative weight and floor");
    doReset();
    writeWeight(3'd2, 32'hFFFF_0000);
    runStep("negative", 8'h04, 32'hFFFF_0000);
    runStep("decay neg", 8'h00, 32'hFFFF_2000);

    $display("[TB] saturation or wrap");
    doReset();
    for (int i = 0; i < 8; i++) writeWeight(3'(i), 32'h7FFF_0000);
    runStep("all spikes", 8'hFF, satExpected);

    $display("[TB] overrun");
    doReset();
    writeWeight(3'd0, 32'h0005_0000);
    writeWeight(3'd1, 32'h0003_0000);
    validBase = validCount;
    overrunBase = overrunCount;
    applyStimulus(8'h03, 3, 0, 3'd0, 32'd0, latency);
    checkOutput("overrun latency", 64'(latency), 64'd9);
    checkOutput("overrun current", {32'd0, current}, 64'h0008_0000);
    checkOutput("overrun pulses", 64'(overrunCount - overrunBase), 64'd1);
    checkOutput("overrun valids", 64'(validCount - validBase), 64'd1);
    validBase = validCount;
    overrunBase = overrunCount;
    applyStimulus(8'h03, 9, 0, 3'd0, 32'd0, latency);
    checkOutput("update overrun current", {32'd0, current}, 64'h000F_0000);
    checkOutput("update overrun pulses", 64'(overrunCount - overrunBase), 64'd1);
    checkOutput("update overrun valids", 64'(validCount - validBase), 64'd1);

    $display("[TB] write hazard");
    doReset();
    writeWeight(3'd4, 32'h0001_0000);
    applyStimulus(8'h10, 0, 5, 3'd4, 32'h0002_0000, latency);
    checkOutput("hazard current", {32'd0, current}, 64'h0001_0000);
    runStep("after hazard", 8'h10, 32'h0002_E000);

    $display("[TB] reset mid-pass");
    validBase = validCount;
    @(negedge clk);
    step = 1'b1;
    spike_in = 8'h10;
    @(negedge clk);
    step = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("midpass busy", {63'd0, busy}, 64'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("abort current", {32'd0, current}, 64'd0);
    checkOutput("abort busy", {63'd0, busy}, 64'd0);
    checkOutput("abort valid", {63'd0, current_valid}, 64'd0);
    checkOutput("abort overrun", {63'd0, overrun}, 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    checkOutput("abort no valid", 64'(validCount - validBase), 64'd0);
    runStep("weights cleared", 8'h10, 32'h0000_0000);
    writeWeight(3'd1, 32'h0003_0000);
    runStep("first after reset", 8'h02, 32'h0003_0000);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
